// File: rtl/serial_stream_gen_if.sv
// Handshake and serial-output bundle for serial_stream_gen.
// The DUT connects through the slave modport, the word source through master.
interface serial_stream_gen_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] load_data;
    logic             load_valid;
    logic             load_ready;
    logic             abort;
    logic             ser_out;
    logic             ser_valid;
    logic             word_start;
    logic             busy;

    modport master (
        output load_data, load_valid, abort,
        input  load_ready, ser_out, ser_valid, word_start, busy
    );

    modport slave (
        input  load_data, load_valid, abort,
        output load_ready, ser_out, ser_valid, word_start, busy
    );
endinterface

// File: rtl/serial_stream_gen.sv
// Parallel-to-serial word generator with a one-word holding register so a
// continuously fed source produces a gap-free bit stream.
module serial_stream_gen #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    serial_stream_gen_if.slave  bus
);
    localparam int               CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] hold;
    logic             hold_full;
    logic [CNT_W-1:0] cnt;

    logic xfer;
    logic last_bit;

    function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] v);
        if (MSB_FIRST) return {v[WIDTH-2:0], 1'b0};
        else           return {1'b0, v[WIDTH-1:1]};
    endfunction

    // load_ready is purely registered, so the transfer qualifier never loops back
    assign xfer     = bus.load_valid && !hold_full;
    assign last_bit = (cnt == LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (bus.abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (xfer) state_nxt = SHIFT;
                SHIFT:   if (last_bit && !hold_full && !xfer) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sreg      <= '0;
            hold      <= '0;
            hold_full <= 1'b0;
            cnt       <= '0;
        end else if (bus.abort) begin
            sreg      <= '0;
            hold_full <= 1'b0;
            cnt       <= '0;
        end else if (state == IDLE) begin
            cnt <= '0;
            if (xfer) sreg <= bus.load_data;
        end else if (!last_bit) begin
            sreg <= shift_once(sreg);
            cnt  <= cnt + 1'b1;
            if (xfer) begin
                hold      <= bus.load_data;
                hold_full <= 1'b1;
            end
        end else begin
            // Word boundary: the held word wins, else a same-edge transfer bypasses hold
            cnt <= '0;
            if (hold_full) begin
                sreg      <= hold;
                hold_full <= 1'b0;
            end else if (xfer) begin
                sreg <= bus.load_data;
            end else begin
                sreg <= '0;
            end
        end
    end

    always_comb begin
        bus.ser_valid  = (state == SHIFT);
        bus.ser_out    = 1'b0;
        if (bus.ser_valid) bus.ser_out = MSB_FIRST ? sreg[WIDTH-1] : sreg[0];
        bus.word_start = bus.ser_valid && (cnt == '0);
        bus.busy       = bus.ser_valid || hold_full;
        bus.load_ready = !hold_full;
    end
endmodule
